// File: rtl/genius_core.sv
// genius_core: colour-sequence memory game controller.
// Draws a pseudo-random colour per round, replays the whole sequence on
// one-hot outputs with programmable on/gap timing, then checks
// edge-detected button presses against it with an idle timeout.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start after reset
// S_APPEND   | one cycle: store drawn colour at mem[level], level++
// S_SHOW_ON  | colour mem[step] lit for SHOW_TICKS cycles
// S_SHOW_OFF | dark for GAP_TICKS cycles, then next step or INPUT
// S_INPUT    | compare button edges against mem[step], idle timeout
// S_WIN      | full MAX_LEN sequence repeated; level/step frozen
// S_LOSE     | wrong press or timeout; level/step frozen
module genius_core #(
    parameter int          N_COLORS      = 3,
    parameter int          MAX_LEN       = 16,
    parameter int          SHOW_TICKS    = 25000000,
    parameter int          GAP_TICKS     = 5000000,
    parameter int          TIMEOUT_TICKS = 250000000,
    parameter logic [15:0] SEED          = 16'hACE1,
    localparam int         LW            = $clog2(MAX_LEN + 1)
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [N_COLORS-1:0] i_btn,
    output logic [N_COLORS-1:0] o_color_out,
    output logic                o_showing,
    output logic                o_awaiting,
    output logic [LW-1:0]       o_level,
    output logic [LW-1:0]       o_step,
    output logic                o_win,
    output logic                o_lose,
    output logic [2:0]          o_state_dbg
);

    // colour index width, memory address width and timer width
    localparam int CW    = (N_COLORS > 1) ? $clog2(N_COLORS) : 1;
    localparam int CW1   = CW + 1;
    localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int T_A   = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int T_MAX = (T_A > TIMEOUT_TICKS) ? T_A : TIMEOUT_TICKS;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TW-1:0]       SHOW_LAST = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0]       GAP_LAST  = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0]       TO_LAST   = TW'(TIMEOUT_TICKS - 1);
    localparam logic [LW-1:0]       LEN_MAX   = LW'(MAX_LEN);
    localparam logic [CW1-1:0]      NC_EXT    = CW1'(N_COLORS);
    localparam logic [N_COLORS-1:0] ONE_HOT0  = N_COLORS'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_APPEND   = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_INPUT    = 3'd4,
        S_WIN      = 3'd5,
        S_LOSE     = 3'd6
    } state_t;

    state_t              r_state;
    logic [LW-1:0]       r_level;
    logic [LW-1:0]       r_step;
    logic [TW-1:0]       r_timer;
    logic [15:0]         r_lfsr;
    logic [N_COLORS-1:0] r_btn_q;
    logic [CW-1:0]       r_mem [0:(1<<AW)-1];

    state_t              w_state_nxt;
    logic [LW-1:0]       w_level_nxt;
    logic [LW-1:0]       w_step_nxt;
    logic [TW-1:0]       w_timer_nxt;
    logic                w_mem_we;
    logic                w_lfsr_fb;
    logic [CW-1:0]       w_draw_raw;
    logic [CW-1:0]       w_draw;
    logic [N_COLORS-1:0] w_press;
    logic [N_COLORS-1:0] w_expect;
    logic                w_last_step;

    // LFSR feedback (taps 16,14,13,11) and folded colour draw
    always_comb begin
        w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
        w_draw_raw = r_lfsr[CW-1:0];
        if ({1'b0, w_draw_raw} >= NC_EXT) begin
            w_draw = CW'({1'b0, w_draw_raw} - NC_EXT);
        end else begin
            w_draw = w_draw_raw;
        end
    end

    // rising-edge presses and the colour expected at the current step
    always_comb begin
        w_press     = i_btn & ~r_btn_q;
        w_expect    = ONE_HOT0 << r_mem[r_step[AW-1:0]];
        w_last_step = (r_step == (r_level - LW'(1)));
    end

    // LFSR and button history run every cycle regardless of state
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_lfsr  <= SEED;
            r_btn_q <= '0;
        end else begin
            r_lfsr  <= {r_lfsr[14:0], w_lfsr_fb};
            r_btn_q <= i_btn;
        end
    end

    // FSM state, level, step and timer registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_level <= '0;
            r_step  <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_step  <= w_step_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // sequence memory; contents are don't-care after reset
    always_ff @(posedge i_clock) begin
        if (w_mem_we) begin
            r_mem[r_level[AW-1:0]] <= w_draw;
        end
    end

    // next-state logic for the game FSM
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_step_nxt  = r_step;
        w_timer_nxt = r_timer;
        w_mem_we    = 1'b0;
        case (r_state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (i_start) begin
                    w_level_nxt = '0;
                    w_state_nxt = S_APPEND;
                end
            end
            S_APPEND: begin
                w_mem_we    = 1'b1;
                w_level_nxt = r_level + LW'(1);
                w_step_nxt  = '0;
                w_timer_nxt = '0;
                w_state_nxt = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (r_timer == SHOW_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_SHOW_OFF;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_SHOW_OFF: begin
                if (r_timer == GAP_LAST) begin
                    w_timer_nxt = '0;
                    if (w_last_step) begin
                        w_step_nxt  = '0;
                        w_state_nxt = S_INPUT;
                    end else begin
                        w_step_nxt  = r_step + LW'(1);
                        w_state_nxt = S_SHOW_ON;
                    end
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_INPUT: begin
                if (w_press == '0) begin
                    if (r_timer == TO_LAST) begin
                        w_state_nxt = S_LOSE;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end else if (w_press == w_expect) begin
                    if (w_last_step) begin
                        w_state_nxt = (r_level == LEN_MAX) ? S_WIN : S_APPEND;
                    end else begin
                        w_step_nxt  = r_step + LW'(1);
                        w_timer_nxt = '0;
                    end
                end else begin
                    // wrong colour or several new bits in one cycle
                    w_state_nxt = S_LOSE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // outputs decoded from registered state only
    always_comb begin
        o_color_out = (r_state == S_SHOW_ON) ? w_expect : '0;
        o_showing   = (r_state == S_SHOW_ON) || (r_state == S_SHOW_OFF);
        o_awaiting  = (r_state == S_INPUT);
        o_win       = (r_state == S_WIN);
        o_lose      = (r_state == S_LOSE);
        o_level     = r_level;
        o_step      = r_step;
        o_state_dbg = r_state;
    end

endmodule

// File: tb/tb_genius_core.sv
// tb_genius_core: directed, table-driven bench for genius_core with a
// reference LFSR model supplying the expected colour sequence.
module tb_genius_core;

    localparam int NC = 4;
    localparam int ML = 3;
    localparam int ST = 4;
    localparam int GT = 2;
    localparam int TT = 20;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_APPEND   = 3'd1;
    localparam logic [2:0] S_SHOW_ON  = 3'd2;
    localparam logic [2:0] S_SHOW_OFF = 3'd3;
    localparam logic [2:0] S_INPUT    = 3'd4;
    localparam logic [2:0] S_WIN      = 3'd5;
    localparam logic [2:0] S_LOSE     = 3'd6;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] btn;
    logic [3:0] color_out;
    logic       showing;
    logic       awaiting;
    logic [1:0] level;
    logic [1:0] step;
    logic       win;
    logic       lose;
    logic [2:0] state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_lfsr;
    logic [1:0]  seq [0:2];

    typedef struct {
        logic       start;
        logic [3:0] btn;
        logic [2:0] st;
        int         lvl;
        int         stp;
    } vec_t;

    genius_core #(
        .N_COLORS(NC), .MAX_LEN(ML), .SHOW_TICKS(ST), .GAP_TICKS(GT),
        .TIMEOUT_TICKS(TT), .SEED(16'hACE1)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_btn(btn),
        .o_color_out(color_out), .o_showing(showing), .o_awaiting(awaiting),
        .o_level(level), .o_step(step), .o_win(win), .o_lose(lose),
        .o_state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // reference 16-bit Fibonacci LFSR, taps 16,14,13,11
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string fld, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s %s: got %0d want %0d", tag, fld, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] st, input int lvl, input int stp);
        logic [3:0] ec;
        ec = (st == S_SHOW_ON) ? (4'b0001 << seq[stp]) : 4'b0000;
        chk(tag, "state",    int'(state_dbg), int'(st));
        chk(tag, "level",    int'(level), lvl);
        chk(tag, "step",     int'(step), stp);
        chk(tag, "color",    int'(color_out), int'(ec));
        chk(tag, "showing",  int'(showing), int'(st == S_SHOW_ON || st == S_SHOW_OFF));
        chk(tag, "awaiting", int'(awaiting), int'(st == S_INPUT));
        chk(tag, "win",      int'(win), int'(st == S_WIN));
        chk(tag, "lose",     int'(lose), int'(st == S_LOSE));
    endtask

    // called while sitting in APPEND; walks the playback into INPUT
    task automatic playback(input string tag, input int lvl, input int app_step,
                            input logic hold_btn, input logic hold_start);
        seq[lvl-1] = m_lfsr[1:0];
        chk_out({tag, "_app"}, S_APPEND, lvl - 1, app_step);
        start = hold_start;
        for (int k = 0; k < lvl; k++) begin
            for (int t = 0; t < ST; t++) begin
                tick();
                chk_out($sformatf("%s_on%0d_%0d", tag, k, t), S_SHOW_ON, lvl, k);
            end
            for (int t = 0; t < GT; t++) begin
                tick();
                chk_out($sformatf("%s_off%0d_%0d", tag, k, t), S_SHOW_OFF, lvl, k);
                if (hold_btn && k == lvl - 1 && t == 0) btn = 4'b0001 << seq[0];
            end
        end
        tick();
        chk_out({tag, "_in"}, S_INPUT, lvl, 0);
    endtask

    task automatic press(input string tag, input logic [3:0] b, input logic [2:0] st,
                         input int lvl, input int stp);
        btn = b;
        tick();
        btn = 4'b0000;
        chk_out(tag, st, lvl, stp);
    endtask

    vec_t vt [0:10];

    initial begin
        // round 1 from reset: IDLE, start, APPEND, 4 lit, 2 dark, INPUT
        vt[0]  = '{1'b0, 4'b0000, S_IDLE,     0, 0};
        vt[1]  = '{1'b1, 4'b0000, S_APPEND,   0, 0};
        vt[2]  = '{1'b0, 4'b0000, S_SHOW_ON,  1, 0};
        vt[3]  = '{1'b0, 4'b0000, S_SHOW_ON,  1, 0};
        vt[4]  = '{1'b0, 4'b0000, S_SHOW_ON,  1, 0};
        vt[5]  = '{1'b0, 4'b0000, S_SHOW_ON,  1, 0};
        vt[6]  = '{1'b0, 4'b0000, S_SHOW_OFF, 1, 0};
        vt[7]  = '{1'b0, 4'b0000, S_SHOW_OFF, 1, 0};
        vt[8]  = '{1'b0, 4'b0000, S_INPUT,    1, 0};
        vt[9]  = '{1'b1, 4'b0000, S_INPUT,    1, 0};
        vt[10] = '{1'b0, 4'b0000, S_INPUT,    1, 0};

        rst = 1'b1; start = 1'b0; btn = 4'b0000;
        seq[0] = 2'd0; seq[1] = 2'd0; seq[2] = 2'd0;
        #12;
        chk_out("reset", S_IDLE, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // test 1: table-driven first round
        for (int i = 0; i <= 10; i++) begin
            start = vt[i].start;
            btn   = vt[i].btn;
            tick();
            if (vt[i].st == S_APPEND) seq[vt[i].lvl] = m_lfsr[1:0];
            chk_out($sformatf("t1v%0d", i), vt[i].st, vt[i].lvl, vt[i].stp);
        end
        start = 1'b0;

        // test 2: correct presses through all rounds to WIN
        press("t2r1p0", 4'b0001 << seq[0], S_APPEND, 1, 0);
        playback("t2r2", 2, 0, 1'b0, 1'b0);
        press("t2r2p0", 4'b0001 << seq[0], S_INPUT, 2, 1);
        tick(); chk_out("t2r2rel", S_INPUT, 2, 1);
        press("t2r2p1", 4'b0001 << seq[1], S_APPEND, 2, 1);
        playback("t2r3", 3, 1, 1'b0, 1'b0);
        press("t2r3p0", 4'b0001 << seq[0], S_INPUT, 3, 1);
        tick(); chk_out("t2r3rel0", S_INPUT, 3, 1);
        press("t2r3p1", 4'b0001 << seq[1], S_INPUT, 3, 2);
        tick(); chk_out("t2r3rel1", S_INPUT, 3, 2);
        press("t2r3p2", 4'b0001 << seq[2], S_WIN, 3, 2);
        for (int i = 0; i < 50; i++) begin
            tick();
            chk_out($sformatf("t2win%0d", i), S_WIN, 3, 2);
        end

        // test 3: wrong colour at round 2 step 1, then restart
        start = 1'b1; tick();
        playback("t3r1", 1, 2, 1'b0, 1'b0);
        press("t3r1p0", 4'b0001 << seq[0], S_APPEND, 1, 0);
        playback("t3r2", 2, 0, 1'b0, 1'b0);
        press("t3r2p0", 4'b0001 << seq[0], S_INPUT, 2, 1);
        tick(); chk_out("t3r2rel", S_INPUT, 2, 1);
        press("t3wrong", 4'b0001 << ((seq[1] + 2'd1) & 2'd3), S_LOSE, 2, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("t3hold%0d", i), S_LOSE, 2, 1);
        end
        start = 1'b1; tick();
        playback("t3re", 1, 1, 1'b0, 1'b0);

        // test 4: timeout after exactly 20 idle edges
        for (int i = 1; i < TT; i++) begin
            tick();
            chk_out($sformatf("t4idle%0d", i), S_INPUT, 1, 0);
        end
        tick(); chk_out("t4timeout", S_LOSE, 1, 0);
        start = 1'b1; tick();
        playback("t4r1", 1, 0, 1'b0, 1'b0);
        press("t4r1p0", 4'b0001 << seq[0], S_APPEND, 1, 0);
        playback("t4r2", 2, 0, 1'b0, 1'b0);
        for (int i = 1; i < TT; i++) begin
            tick();
            chk_out($sformatf("t4b_idle%0d", i), S_INPUT, 2, 0);
        end
        press("t4late", 4'b0001 << seq[0], S_INPUT, 2, 1);
        for (int i = 1; i < TT; i++) begin
            tick();
            chk_out($sformatf("t4c_idle%0d", i), S_INPUT, 2, 1);
        end
        tick(); chk_out("t4timeout2", S_LOSE, 2, 1);

        // test 5: button held into INPUT is ignored; two new bits lose
        start = 1'b1; tick();
        playback("t5", 1, 1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("t5held%0d", i), S_INPUT, 1, 0);
        end
        btn = 4'b0000;
        tick(); chk_out("t5release", S_INPUT, 1, 0);
        press("t5double", 4'b0011, S_LOSE, 1, 0);

        // test 6: start ignored mid-game, async reset during SHOW_ON
        start = 1'b1; tick();
        playback("t6", 1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("t6start_in%0d", i), S_INPUT, 1, 0);
        end
        start = 1'b0;
        press("t6p0", 4'b0001 << seq[0], S_APPEND, 1, 0);
        seq[1] = m_lfsr[1:0];
        tick(); chk_out("t6on0", S_SHOW_ON, 2, 0);
        tick(); chk_out("t6on1", S_SHOW_ON, 2, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_out("t6async", S_IDLE, 0, 0);
        tick(); chk_out("t6rst0", S_IDLE, 0, 0);
        rst = 1'b0;
        tick(); chk_out("t6rel", S_IDLE, 0, 0);
        start = 1'b1; tick();
        playback("t6after", 1, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
